div_clk_monitor: RTL and testbench
==================================

Name: div_clk_monitor

Overview:
Downstream consumer of the odd-ratio clock divider output. It samples the divided clock in the source clk_i domain and measures its period and high time in clk_i cycles. It checks the measurements against the expected ratio and a 50%-duty tolerance, and reports lock, error and timeout status. Sits beside the divider in the clock-generation subsystem as a built-in health monitor for bring-up and test.

Parameters:
EXP_PERIOD, 7, expected divided-clock period in clk_i cycles (odd or even, >=3)
CW, 8, width of the period/high counters and outputs
LOCK_CNT, 4, consecutive good periods required to assert lock_o (1..15)
TIMEOUT, 64, clk_i cycles without a divided-clock rising edge before timeout (< 2^CW)

Ports:
clk_i  in  1  source clock; the only clock in the block
rst_n  in  1  asynchronous active-low reset
clk_div_i  in  1  divided clock under test, sampled as data
mon_en_i  in  1  monitor enable; low forces IDLE
err_clr_i  in  1  one-cycle pulse that clears the sticky err_o and timeout_o
period_o  out  CW  last measured period (clk_i cycles)
high_o  out  CW  last measured high time (clk_i cycles)
meas_valid_o  out  1  one-cycle pulse when period_o/high_o update
lock_o  out  1  LOCK_CNT consecutive good periods seen
err_o  out  1  sticky: a completed period failed a check
timeout_o  out  1  sticky: no rising edge within TIMEOUT cycles

Behaviour:
- Reset (rst_n low, asynchronous): all flops clear. Outputs period_o=0, high_o=0, meas_valid_o=0, lock_o=0, err_o=0, timeout_o=0. State = IDLE.
- Input path: 2-flop synchronizer s1->s2, then a delay flop s3. The rise pulse is s2 & ~s3; the level is s2.
- FSM states: IDLE, WAIT_RISE, MEASURE.
  - IDLE: counters cleared, lock_o=0. Goes to WAIT_RISE when mon_en_i=1.
  - WAIT_RISE: on rise, clears the counters and goes to MEASURE. This first edge is never reported.
  - MEASURE: each cycle, per_cnt increments and hi_cnt increments if the level is 1. Both saturate at 2^CW-1.
  - On rise in MEASURE, the period closes. per_cnt includes the rise cycle, so a divide-by-7 input gives 7. period_o and high_o load on that edge, and meas_valid_o=1 for exactly the next cycle. The counters restart (per_cnt=1, hi_cnt=level) and the state stays MEASURE.
- Good period: period==EXP_PERIOD and |2*high - period| <= 1.
  - Divide-by-7 at 50% gives high of 3 or 4; both pass.
  - A good period increments good_cnt (saturating at LOCK_CNT). lock_o=1 when good_cnt==LOCK_CNT.
  - A bad period sets err_o, clears good_cnt and drops lock_o the same cycle that meas_valid_o rises.
- Timeout: if the cycle count since the last rise reaches TIMEOUT in WAIT_RISE or MEASURE:
  - timeout_o=1 (sticky), err_o=1, lock_o=0, good_cnt=0.
  - State goes to WAIT_RISE. No meas_valid_o pulse.
- err_clr_i: clears err_o and timeout_o the next cycle. If a new error or timeout fires in the same cycle, the set wins.
- mon_en_i low mid-measurement: next cycle state=IDLE and lock_o=0. The partial period is discarded. period_o, high_o and the sticky flags hold.
- Saturation: a stuck-high input saturates hi_cnt; timeout still fires.

Optional Feature:
Macro DIV_MON_MINMAX_EN.
- Defined: adds outputs per_min_o and per_max_o [CW]. Reset values are all-ones and zero respectively. Each updates on every meas_valid_o to the running min/max of period_o. Both reinitialize on err_clr_i.
- Undefined: these ports and registers do not exist. All other behaviour is identical.

Test Plan:
- Ideal divide-by-7 (high 4, low 3 clk_i cycles), mon_en_i=1 -> first meas_valid_o on the 2nd rise; period_o=7, high_o=4; lock_o=1 after the 5th rise (4 good periods); err_o=0.
- Divide-by-8 stream with EXP_PERIOD=7 -> period_o=8, err_o=1 on the first meas_valid_o, lock_o stays 0; err_clr_i pulse -> err_o=0 the next cycle, then 1 again at the next period.
- Duty fault: high 6, low 1 (period 7) -> high_o=6, err_o=1, lock_o drops from 1 to 0 in the same cycle.
- clk_div_i held at 0 after lock -> timeout_o=1 and err_o=1 exactly TIMEOUT=64 cycles after the last rise, lock_o=0; resumed clock re-locks after 1+4 rises.
- rst_n asserted asynchronously mid-MEASURE -> all outputs 0 immediately without a clk_i edge; mon_en_i low mid-period -> no meas_valid_o, period_o holds.
- With DIV_MON_MINMAX_EN: periods 7,7,9,6 -> per_min_o=6, per_max_o=9.

Source files
------------

// File: rtl/div_clk_monitor.sv
// div_clk_monitor: health monitor for a divided clock. The divided clock is
// sampled as data in the clk_i domain, and its period and high time are
// measured in clk_i cycles. Each period is checked against the expected ratio
// and a 50% duty tolerance. The block reports lock, sticky error and sticky
// timeout status.
// Optional build macro DIV_MON_MINMAX_EN adds the running per_min_o/per_max_o
// period statistics.
module div_clk_monitor #(
   parameter int EXP_PERIOD = 7,
   parameter int CW         = 8,
   parameter int LOCK_CNT   = 4,
   parameter int TIMEOUT    = 64
) (
   input  logic          clk_i,
   input  logic          rst_n,
   input  logic          clk_div_i,
   input  logic          mon_en_i,
   input  logic          err_clr_i,
   output logic [CW-1:0] period_o,
   output logic [CW-1:0] high_o,
   output logic          meas_valid_o,
   output logic          lock_o,
   output logic          err_o,
`ifdef DIV_MON_MINMAX_EN
   output logic          timeout_o,
   output logic [CW-1:0] per_min_o,
   output logic [CW-1:0] per_max_o
`else
   output logic          timeout_o
`endif
);

   localparam logic [CW-1:0]        EXP_W    = CW'(EXP_PERIOD);
   localparam logic [CW-1:0]        TMO_LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0]        CNT_MAX  = '1;
   localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
   localparam logic [3:0]           LOCK_W   = 4'(LOCK_CNT);
   localparam logic signed [CW+2:0] DIFF_ONE = (CW+3)'(1);

   typedef enum logic [1:0] {IDLE, WAIT_RISE, MEASURE} state_t;

   // Saturating increment for the period and high-time counters
   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

   // A period is good when it matches the ratio and |2*high - period| <= 1
   function automatic logic period_good(input logic [CW-1:0] per,
                                        input logic [CW-1:0] hi);
      logic signed [CW+2:0] diff;
      diff = $signed({2'b00, hi, 1'b0}) - $signed({3'b000, per});
      return (per == EXP_W) && (diff >= -DIFF_ONE) && (diff <= DIFF_ONE);
   endfunction

   logic          s1, s2, s3;
   logic          rise, level;
   state_t        state, state_nx;
   logic [CW-1:0] per_cnt, hi_cnt, tmo_cnt;
   logic [3:0]    good_cnt;
   logic          start, close, tmo_fire, tmo_hit, go_idle;
   logic          good, bad;

   assign rise    = s2 & ~s3;
   assign level   = s2;
   assign tmo_hit = (tmo_cnt == TMO_LAST);
   assign go_idle = (state_nx == IDLE);
   assign good    = close & period_good(per_cnt, hi_cnt);
   assign bad     = close & ~period_good(per_cnt, hi_cnt);
   assign lock_o  = (good_cnt == LOCK_W);

   // Two-flop synchronizer plus a delay flop for rising-edge detection
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= clk_div_i;
         s2 <= s1;
         s3 <= s2;
      end
   end

   // FSM state register
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next state and per-cycle strobes; a rise beats a coincident timeout
   always_comb begin
      state_nx = state;
      start    = 1'b0;
      close    = 1'b0;
      tmo_fire = 1'b0;
      if (!mon_en_i) begin
         state_nx = IDLE;
      end else begin
         case (state)
            IDLE: state_nx = WAIT_RISE;
            WAIT_RISE: begin
               if (rise) begin
                  start    = 1'b1;
                  state_nx = MEASURE;
               end else if (tmo_hit) begin
                  tmo_fire = 1'b1;
               end
            end
            MEASURE: begin
               if (rise) begin
                  close = 1'b1;
               end else if (tmo_hit) begin
                  tmo_fire = 1'b1;
                  state_nx = WAIT_RISE;
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   // Period/high/timeout counters; the rise cycle counts as cycle 1 of a period
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         per_cnt <= '0;
         hi_cnt  <= '0;
         tmo_cnt <= '0;
      end else if (go_idle || tmo_fire) begin
         per_cnt <= '0;
         hi_cnt  <= '0;
         tmo_cnt <= '0;
      end else if (start || close) begin
         per_cnt <= CNT_ONE;
         hi_cnt  <= {{(CW-1){1'b0}}, level};
         tmo_cnt <= '0;
      end else if (state == MEASURE) begin
         per_cnt <= sat_inc(per_cnt);
         if (level) hi_cnt <= sat_inc(hi_cnt);
         tmo_cnt <= tmo_cnt + 1'b1;
      end else if (state == WAIT_RISE) begin
         tmo_cnt <= tmo_cnt + 1'b1;
      end
   end

   // Measurement outputs load when a period closes
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         period_o     <= '0;
         high_o       <= '0;
         meas_valid_o <= 1'b0;
      end else begin
         meas_valid_o <= close;
         if (close) begin
            period_o <= per_cnt;
            high_o   <= hi_cnt;
         end
      end
   end

   // Lock counter and sticky flags; a new error wins over a clear
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         good_cnt  <= '0;
         err_o     <= 1'b0;
         timeout_o <= 1'b0;
      end else begin
         if (go_idle || tmo_fire || bad)       good_cnt <= '0;
         else if (good && good_cnt != LOCK_W)  good_cnt <= good_cnt + 1'b1;

         if (tmo_fire || bad) err_o <= 1'b1;
         else if (err_clr_i)  err_o <= 1'b0;

         if (tmo_fire)       timeout_o <= 1'b1;
         else if (err_clr_i) timeout_o <= 1'b0;
      end
   end

`ifdef DIV_MON_MINMAX_EN
   logic [CW-1:0] min_base, max_base;

   assign min_base = err_clr_i ? CNT_MAX : per_min_o;
   assign max_base = err_clr_i ? '0      : per_max_o;

   // Running min/max of reported periods, restarted by err_clr_i
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         per_min_o <= CNT_MAX;
         per_max_o <= '0;
      end else if (close) begin
         per_min_o <= (per_cnt < min_base) ? per_cnt : min_base;
         per_max_o <= (per_cnt > max_base) ? per_cnt : max_base;
      end else if (err_clr_i) begin
         per_min_o <= CNT_MAX;
         per_max_o <= '0;
      end
   end
`endif

endmodule

// File: tb/tb_div_clk_monitor.sv
// Self-checking bench for div_clk_monitor: drives divided-clock waveforms in
// step with clk_i, predicts each reported period in a scoreboard, and checks
// lock/error/timeout timing inline in each scenario task.
module tb_div_clk_monitor;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          clk_div = 1'b0;
   logic          mon_en = 1'b0;
   logic          err_clr = 1'b0;
   logic [CW-1:0] period_o, high_o;
   logic          meas_valid_o, lock_o, err_o, timeout_o;
`ifdef DIV_MON_MINMAX_EN
   logic [CW-1:0] per_min_o, per_max_o;
`endif

   int tests = 0;
   int fails = 0;

   typedef struct {int per; int hi;} exp_t;
   exp_t sb[$];
   exp_t mon_e;
   logic pend_v = 1'b0;
   int   pend_per = 0;
   int   pend_hi = 0;

   div_clk_monitor #(.EXP_PERIOD(7), .CW(CW), .LOCK_CNT(4), .TIMEOUT(64)) dut (
      .clk_i(clk),
      .rst_n(rst_n),
      .clk_div_i(clk_div),
      .mon_en_i(mon_en),
      .err_clr_i(err_clr),
      .period_o(period_o),
      .high_o(high_o),
      .meas_valid_o(meas_valid_o),
      .lock_o(lock_o),
      .err_o(err_o),
`ifdef DIV_MON_MINMAX_EN
      .timeout_o(timeout_o),
      .per_min_o(per_min_o),
      .per_max_o(per_max_o)
`else
      .timeout_o(timeout_o)
`endif
   );

   always #5 clk = ~clk;

   // Scoreboard consumer: every meas_valid_o pulse must match a predicted period
   always @(negedge clk) begin
      if (rst_n && meas_valid_o) begin
         tests++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL meas_unexpected: period_o=%0d high_o=%0d, required no pulse", period_o, high_o);
         end else begin
            mon_e = sb.pop_front();
            if (period_o !== CW'(mon_e.per) || high_o !== CW'(mon_e.hi)) begin
               fails++;
               $display("FAIL meas_value: period_o=%0d high_o=%0d, required %0d/%0d",
                        period_o, high_o, mon_e.per, mon_e.hi);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // One divided-clock period: rise now, hi cycles high then lo cycles low.
   // The rise closes the previous period, so its expectation is pushed here.
   task automatic drive_cycle(input int hi, input int lo);
      exp_t t;
      clk_div = 1'b1;
      if (pend_v && mon_en) begin
         t.per = pend_per;
         t.hi  = pend_hi;
         sb.push_back(t);
      end
      pend_v   = mon_en;
      pend_per = hi + lo;
      pend_hi  = hi;
      repeat (hi) @(negedge clk);
      clk_div = 1'b0;
      repeat (lo) @(negedge clk);
   endtask

   task automatic sb_break();
      pend_v = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; mon_en = 1'b0; clk_div = 1'b0; err_clr = 1'b0;
      repeat (2) @(negedge clk);
      tests++;
      if ({period_o, high_o} !== '0) begin
         fails++; $display("FAIL reset_meas: period_o=%0d high_o=%0d required 0/0", period_o, high_o);
      end
      tests++;
      if ({meas_valid_o, lock_o, err_o, timeout_o} !== 4'b0000) begin
         fails++; $display("FAIL reset_flags: vld/lock/err/tmo=%b required 0000",
                           {meas_valid_o, lock_o, err_o, timeout_o});
      end
`ifdef DIV_MON_MINMAX_EN
      tests++;
      if (per_min_o !== 8'hFF || per_max_o !== 8'h00) begin
         fails++; $display("FAIL reset_minmax: min=%0d max=%0d required 255/0", per_min_o, per_max_o);
      end
`endif
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_lock();
      mon_en = 1'b1;
      repeat (3) @(negedge clk);
      repeat (4) drive_cycle(4, 3);
      tests++;
      if (lock_o !== 1'b0) begin
         fails++; $display("FAIL lock_early: lock_o=%b after 4 rises, required 0", lock_o);
      end
      drive_cycle(4, 3);
      tests++;
      if (lock_o !== 1'b1) begin
         fails++; $display("FAIL lock_set: lock_o=%b after 5 rises, required 1", lock_o);
      end
      tests++;
      if ({err_o, timeout_o} !== 2'b00) begin
         fails++; $display("FAIL lock_flags: err/tmo=%b required 00", {err_o, timeout_o});
      end
      tests++;
      if (period_o !== 8'd7 || high_o !== 8'd4) begin
         fails++; $display("FAIL lock_meas: period_o=%0d high_o=%0d required 7/4", period_o, high_o);
      end
   endtask

   task automatic test_duty();
      drive_cycle(6, 1);
      fork
         drive_cycle(4, 3);
         begin
            repeat (2) @(negedge clk);
            tests++;
            if ({lock_o, meas_valid_o} !== 2'b10) begin
               fails++; $display("FAIL duty_before: lock/vld=%b required 10", {lock_o, meas_valid_o});
            end
            @(negedge clk);
            tests++;
            if ({meas_valid_o, lock_o, err_o} !== 3'b101) begin
               fails++; $display("FAIL duty_drop: vld/lock/err=%b required 101", {meas_valid_o, lock_o, err_o});
            end
            tests++;
            if (high_o !== 8'd6) begin
               fails++; $display("FAIL duty_high: high_o=%0d required 6", high_o);
            end
         end
      join
   endtask

   task automatic test_timeout();
      repeat (4) drive_cycle(4, 3);
      tests++;
      if (lock_o !== 1'b1) begin
         fails++; $display("FAIL tmo_prelock: lock_o=%b required 1", lock_o);
      end
      sb_break();
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      tests++;
      if ({err_o, timeout_o} !== 2'b00) begin
         fails++; $display("FAIL tmo_clr: err/tmo=%b required 00", {err_o, timeout_o});
      end
      repeat (58) @(negedge clk);
      tests++;
      if (timeout_o !== 1'b0) begin
         fails++; $display("FAIL tmo_early: timeout_o=%b at 63 cycles, required 0", timeout_o);
      end
      @(negedge clk);
      tests++;
      if ({timeout_o, err_o, lock_o} !== 3'b110) begin
         fails++; $display("FAIL tmo_fire: tmo/err/lock=%b at 64 cycles, required 110", {timeout_o, err_o, lock_o});
      end
      repeat (4) drive_cycle(4, 3);
      tests++;
      if ({lock_o, timeout_o} !== 2'b01) begin
         fails++; $display("FAIL tmo_relock_early: lock/tmo=%b required 01", {lock_o, timeout_o});
      end
      drive_cycle(4, 3);
      tests++;
      if (lock_o !== 1'b1) begin
         fails++; $display("FAIL tmo_relock: lock_o=%b required 1", lock_o);
      end
   endtask

   task automatic test_ratio();
      mon_en = 1'b0;
      sb_break();
      repeat (2) @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      tests++;
      if ({err_o, timeout_o, lock_o} !== 3'b000) begin
         fails++; $display("FAIL ratio_start: err/tmo/lock=%b required 000", {err_o, timeout_o, lock_o});
      end
      mon_en = 1'b1;
      repeat (3) @(negedge clk);
      drive_cycle(4, 4);
      fork
         drive_cycle(4, 4);
         begin
            repeat (3) @(negedge clk);
            tests++;
            if ({err_o, lock_o} !== 2'b10 || period_o !== 8'd8) begin
               fails++; $display("FAIL ratio_err: err/lock=%b period_o=%0d required 10/8", {err_o, lock_o}, period_o);
            end
            err_clr = 1'b1;
            @(negedge clk);
            err_clr = 1'b0;
            tests++;
            if (err_o !== 1'b0) begin
               fails++; $display("FAIL ratio_clr: err_o=%b required 0", err_o);
            end
         end
      join
      drive_cycle(4, 4);
      tests++;
      if ({err_o, lock_o} !== 2'b10) begin
         fails++; $display("FAIL ratio_reerr: err/lock=%b required 10", {err_o, lock_o});
      end
   endtask

   task automatic test_enable();
      mon_en = 1'b0;
      sb_break();
      repeat (2) @(negedge clk);
      mon_en = 1'b1;
      repeat (3) @(negedge clk);
      repeat (5) drive_cycle(4, 3);
      tests++;
      if ({lock_o, err_o} !== 2'b11) begin
         fails++; $display("FAIL en_locked: lock/err=%b required 11", {lock_o, err_o});
      end
      mon_en = 1'b0;
      sb_break();
      @(negedge clk);
      tests++;
      if ({lock_o, err_o} !== 2'b01 || period_o !== 8'd7) begin
         fails++; $display("FAIL en_drop: lock/err=%b period_o=%0d required 01/7", {lock_o, err_o}, period_o);
      end
      repeat (2) drive_cycle(4, 3);
      repeat (3) @(negedge clk);
      tests++;
      if (period_o !== 8'd7 || sb.size() != 0) begin
         fails++; $display("FAIL en_hold: period_o=%0d pending=%0d required 7/0", period_o, sb.size());
      end
   endtask

   task automatic test_async_reset();
      mon_en = 1'b1;
      repeat (3) @(negedge clk);
      repeat (2) drive_cycle(4, 3);
      fork
         drive_cycle(4, 3);
         begin
            repeat (5) @(negedge clk);
            #2;
            rst_n = 1'b0;
            #1;
            tests++;
            if ({period_o, high_o} !== '0) begin
               fails++; $display("FAIL arst_meas: period_o=%0d high_o=%0d required 0/0", period_o, high_o);
            end
            tests++;
            if ({meas_valid_o, lock_o, err_o, timeout_o} !== 4'b0000) begin
               fails++; $display("FAIL arst_flags: vld/lock/err/tmo=%b required 0000",
                                 {meas_valid_o, lock_o, err_o, timeout_o});
            end
         end
      join
      sb_break();
      mon_en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

`ifdef DIV_MON_MINMAX_EN
   task automatic test_minmax();
      tests++;
      if (per_min_o !== 8'hFF || per_max_o !== 8'h00) begin
         fails++; $display("FAIL mm_init: min=%0d max=%0d required 255/0", per_min_o, per_max_o);
      end
      mon_en = 1'b1;
      repeat (3) @(negedge clk);
      drive_cycle(4, 3);
      drive_cycle(4, 3);
      drive_cycle(5, 4);
      drive_cycle(3, 3);
      drive_cycle(4, 3);
      tests++;
      if (per_min_o !== 8'd6 || per_max_o !== 8'd9) begin
         fails++; $display("FAIL mm_track: min=%0d max=%0d required 6/9", per_min_o, per_max_o);
      end
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      tests++;
      if (per_min_o !== 8'hFF || per_max_o !== 8'h00) begin
         fails++; $display("FAIL mm_clr: min=%0d max=%0d required 255/0", per_min_o, per_max_o);
      end
      mon_en = 1'b0;
      sb_break();
      repeat (2) @(negedge clk);
   endtask
`endif

   initial begin
      test_reset();
      test_lock();
      test_duty();
      test_timeout();
      test_ratio();
      test_enable();
      test_async_reset();
`ifdef DIV_MON_MINMAX_EN
      test_minmax();
`endif
      repeat (5) @(negedge clk);
      tests++;
      if (sb.size() != 0) begin
         fails++; $display("FAIL sb_drain: %0d expected periods never reported, required 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
